// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and constants for the FIFO stream drain block.
package fifo_stream_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATHER,
        STREAM
    } drain_state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_drain_skid.sv
// Two-entry skid buffer: holds popped FIFO words until the consumer takes them.
module stream_skid_buffer
    import fifo_stream_drain_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             take;
    logic             accept;

    assign out_valid = (count != 2'd0);
    assign out_data  = data0;
    assign take      = out_valid && out_ready;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign accept    = push && ((count != 2'(SKID_DEPTH)) || take);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            data0 <= '0;
            data1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({accept, take})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0 <= push_data;
                    end else begin
                        data1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data0 <= push_data;
                    end else begin
                        data0 <= data1;
                        data1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a show-ahead sync_fifo into a valid/ready stream, gathering bursts first.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int BURST_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    input  logic [WIDTH-1:0] fifo_dequeue_value,
    output logic             fifo_dequeue_en,
    output logic             fifo_flush_en,
    input  logic             flush_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             burst_active
);

    localparam int TW = $clog2(BURST_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BURST_TIMEOUT - 1);

    drain_state_t  state;
    drain_state_t  next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic [1:0]    count;

    assign fifo_flush_en   = flush_en;
    // Registered count only, so out_ready never reaches the FIFO pop combinationally.
    assign fifo_dequeue_en = (state == STREAM) && !fifo_empty
                             && (count < 2'(SKID_DEPTH)) && !flush_en;

    always_comb begin
        next_state = state;
        next_timer = timer;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = GATHER;
                    next_timer = '0;
                end
            end
            GATHER: begin
                if (timer != TIMER_LAST) begin
                    next_timer = timer + TW'(1);
                end
                if (fifo_empty) begin
                    next_state = IDLE;
                    next_timer = '0;
                end else if (!fifo_almost_empty || (timer == TIMER_LAST)) begin
                    next_state = STREAM;
                    next_timer = '0;
                end
            end
            STREAM: begin
                if (fifo_empty) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_timer = '0;
            end
        endcase
        if (flush_en) begin
            next_state = IDLE;
            next_timer = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            burst_active <= 1'b0;
        end else begin
            state        <= next_state;
            timer        <= next_timer;
            burst_active <= (next_state == STREAM);
        end
    end

    stream_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_en),
        .push      (fifo_dequeue_en),
        .push_data (fifo_dequeue_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench: a queue models sync_fifo, a second queue tracks words owed to the consumer.
module tb_fifo_stream_drain;

    localparam int WIDTH         = 32;
    localparam int BURST_TIMEOUT = 16;
    localparam int AE_LEVEL      = 2;

    logic             clk;
    logic             reset;
    logic             fifo_empty;
    logic             fifo_almost_empty;
    logic [WIDTH-1:0] fifo_dequeue_value;
    logic             fifo_dequeue_en;
    logic             fifo_flush_en;
    logic             flush_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             burst_active;

    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] delivered_log[$];
    int               checks;
    int               errors;
    int               pop_total;

    fifo_stream_drain #(
        .WIDTH         (WIDTH),
        .BURST_TIMEOUT (BURST_TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fifo_empty         (fifo_empty),
        .fifo_almost_empty  (fifo_almost_empty),
        .fifo_dequeue_value (fifo_dequeue_value),
        .fifo_dequeue_en    (fifo_dequeue_en),
        .fifo_flush_en      (fifo_flush_en),
        .flush_en           (flush_en),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .burst_active       (burst_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_fifo();
        fifo_empty         = (fq.size() == 0);
        fifo_almost_empty  = (fq.size() <= AE_LEVEL);
        fifo_dequeue_value = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push_values(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + WIDTH'(i));
        end
        drive_fifo();
        #1;
    endtask

    // One clock: sample the cycle's handshakes, let the edge happen, then update the models.
    task automatic step();
        logic             dq;
        logic             fl;
        logic             dv;
        logic             rs;
        logic [WIDTH-1:0] dd;
        logic [WIDTH-1:0] v;
        dq = fifo_dequeue_en;
        fl = fifo_flush_en;
        dv = out_valid && out_ready;
        dd = out_data;
        rs = reset;
        @(posedge clk);
        #1;
        if (!rs && dv) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL beat_unexpected: got %0h, required no beat", dd);
            end else begin
                v = expq.pop_front();
                if (dd !== v) begin
                    errors++;
                    $display("[TB] FAIL beat_data: got %0h, required %0h", dd, v);
                end
                delivered_log.push_back(dd);
            end
        end
        if (fl) begin
            fq.delete();
            expq.delete();
        end else if (dq && fq.size() != 0) begin
            v = fq.pop_front();
            pop_total++;
            if (!rs) expq.push_back(v);
        end
        if (rs) expq.delete();
        checks++;
        if (expq.size() > 2) begin
            errors++;
            $display("[TB] FAIL skid_overflow: got %0d held, required <= 2", expq.size());
        end
        drive_fifo();
        #1;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((fq.size() != 0 || expq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (fq.size() != 0 || expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d/%0d left, required 0/0", name, fq.size(), expq.size());
        end
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks += 3;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
            end
            if (fifo_dequeue_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_dequeue: got %b, required 0", fifo_dequeue_en);
            end
            if (burst_active !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_burst_active: got %b, required 0", burst_active);
            end
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        out_ready = 1'b0;
        push_values(32'hA5A5A5A5, 1);
        step();
        for (int i = 0; i < BURST_TIMEOUT; i++) begin
            checks++;
            if (fifo_dequeue_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL gather_no_pop: got %b at gather cycle %0d, required 0", fifo_dequeue_en, i);
            end
            step();
        end
        checks++;
        if (fifo_dequeue_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_pop: got %b, required 1", fifo_dequeue_en);
        end
        step();
        checks += 2;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_valid: got %b, required 1", out_valid);
        end
        if (out_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL timeout_data: got %0h, required a5a5a5a5", out_data);
        end
        out_ready = 1'b1;
        run_until_idle("timeout", 10);
    endtask

    task automatic test_burst();
        out_ready = 1'b1;
        push_values(32'd0, 8);
        for (int t = 1; t <= 11; t++) begin
            step();
            checks++;
            if (t < 3 || t > 10) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL burst_idle_valid: got %b at t=%0d, required 0", out_valid, t);
                end
            end else if (out_valid !== 1'b1 || out_data !== WIDTH'(t - 3)) begin
                errors++;
                $display("[TB] FAIL burst_beat: got v=%b d=%0h at t=%0d, required v=1 d=%0h",
                         out_valid, out_data, t, t - 3);
            end
        end
        run_until_idle("burst", 10);
    endtask

    task automatic test_backpressure();
        int pops_before;
        int delivered_before;
        out_ready = 1'b0;
        pops_before = pop_total;
        delivered_before = delivered_log.size();
        push_values(32'd100, 8);
        for (int i = 0; i < 12; i++) step();
        checks += 4;
        if (pop_total - pops_before != 2) begin
            errors++;
            $display("[TB] FAIL stall_pops: got %0d, required 2", pop_total - pops_before);
        end
        if (fifo_dequeue_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_dequeue: got %b, required 0", fifo_dequeue_en);
        end
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_valid: got %b, required 1", out_valid);
        end
        if (out_data !== 32'd100) begin
            errors++;
            $display("[TB] FAIL stall_data: got %0h, required 64", out_data);
        end
        out_ready = 1'b1;
        run_until_idle("stall_drain", 40);
        checks++;
        if (delivered_log.size() - delivered_before != 8) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d beats, required 8", delivered_log.size() - delivered_before);
        end
    endtask

    task automatic test_flush();
        int n;
        out_ready = 1'b0;
        push_values(32'd300, 8);
        n = 0;
        while (expq.size() < 2 && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (expq.size() != 2) begin
            errors++;
            $display("[TB] FAIL flush_setup: got %0d held, required 2", expq.size());
        end
        flush_en = 1'b1;
        #1;
        checks += 2;
        if (fifo_flush_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_pass: got %b, required 1", fifo_flush_en);
        end
        if (fifo_dequeue_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_pop_same_cycle: got %b, required 0", fifo_dequeue_en);
        end
        step();
        flush_en = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_valid: got %b, required 0", out_valid);
        end
        if (burst_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_burst_active: got %b, required 0", burst_active);
        end
        if (fifo_dequeue_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_pop_after: got %b, required 0", fifo_dequeue_en);
        end
        out_ready = 1'b1;
        run_until_idle("flush", 10);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        push_values(32'd400, 8);
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        checks += 4;
        if (out_valid !== 1'b0 || burst_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got v=%b b=%b, required 0 0", out_valid, burst_active);
        end
        if (fifo_dequeue_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_dequeue: got %b, required 0", fifo_dequeue_en);
        end
        if (out_data !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %0h, required 0", out_data);
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_skid: got %0d held, required 0", expq.size());
        end
        fq.delete();
        delivered_log.delete();
        reset = 1'b0;
        push_values(32'd500, 4);
        run_until_idle("restart", 40);
        checks += 2;
        if (delivered_log.size() != 4) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d beats, required 4", delivered_log.size());
        end else if (delivered_log[0] !== 32'd500) begin
            errors++;
            $display("[TB] FAIL restart_head: got %0h, required 1f4", delivered_log[0]);
        end
    endtask

    task automatic test_random();
        int               n;
        int               budget;
        int               delivered_before;
        logic             pv;
        logic             pr;
        logic [WIDTH-1:0] pd;
        for (int iter = 0; iter < 8; iter++) begin
            n = $urandom_range(1, 20);
            delivered_before = delivered_log.size();
            for (int i = 0; i < n; i++) fq.push_back($urandom);
            drive_fifo();
            #1;
            budget = 0;
            while ((fq.size() != 0 || expq.size() != 0) && budget < 400) begin
                out_ready = ($urandom_range(0, 99) < 60);
                #1;
                pv = out_valid;
                pr = out_ready;
                pd = out_data;
                step();
                budget++;
                if (pv && !pr) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd) begin
                        errors++;
                        $display("[TB] FAIL stall_hold: got v=%b d=%0h, required v=1 d=%0h", out_valid, out_data, pd);
                    end
                end
            end
            out_ready = 1'b1;
            run_until_idle("random", 10);
            checks++;
            if (delivered_log.size() - delivered_before != n) begin
                errors++;
                $display("[TB] FAIL random_count: got %0d beats, required %0d",
                         delivered_log.size() - delivered_before, n);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        pop_total = 0;
        reset     = 1'b1;
        flush_en  = 1'b0;
        out_ready = 1'b0;
        drive_fifo();
        test_reset();
        test_timeout();
        test_burst();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
